// File: rtl/baby_store_loader.sv
// -----------------------------------------------------------------------------
// baby_store_loader
//
// Main store for the Manchester Baby core (2^ADDR_W words x DATA_W bits) with
// a byte-wide host load port and a byte-wide dump port. While either transfer
// is running the core is held in reset and its store port is ignored.
//
// Ports:
//   fpgaGlobalClock  system clock, rising edge
//   reset_i          asynchronous active-low reset
//   cpu_addr_i       core store address
//   cpu_data_i       core write data
//   cpu_rw_en_i      1 = core writes mem[cpu_addr_i] this cycle (IDLE only)
//   cpu_data_o       asynchronous read data to the core (0 during a transfer)
//   stop_lamp_i      core halted indicator
//   cpu_hold_o       1 = hold core in reset
//   ld_start_i       pulse: begin (or restart) a load session
//   ld_valid_i       load byte valid
//   ld_byte_i        load byte, little-endian within each word
//   ld_ready_o       load byte accepted when valid and ready
//   load_done_o      1-cycle pulse after the last word is written
//   dump_start_i     pulse: begin a dump session
//   dump_valid_o     dump byte valid
//   dump_byte_o      dump byte, little-endian within each word
//   dump_ready_i     sink accepts the dump byte
//
// Build option:
//   BABY_STOP_DUMP_EN  when defined, a rising edge of stop_lamp_i in IDLE
//                      starts a dump exactly like dump_start_i. When not
//                      defined, stop_lamp_i is unused.
// -----------------------------------------------------------------------------
module baby_store_loader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int BPW    = DATA_W / 8
) (
   input  logic              fpgaGlobalClock,
   input  logic              reset_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_data_i,
   input  logic              cpu_rw_en_i,
   output logic [DATA_W-1:0] cpu_data_o,
   input  logic              stop_lamp_i,
   output logic              cpu_hold_o,
   input  logic              ld_start_i,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_byte_i,
   output logic              ld_ready_o,
   output logic              load_done_o,
   input  logic              dump_start_i,
   output logic              dump_valid_o,
   output logic [7:0]        dump_byte_o,
   input  logic              dump_ready_i
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
   // word_ptr carries one extra bit so the terminal word never aliases word 0
   localparam logic [ADDR_W:0]  LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DUMP = 2'd2
   } state_e;

   // Extract byte lane 'lane' of a word (lane 0 = bits 7:0)
   function automatic logic [7:0] get_lane(input logic [DATA_W-1:0] word,
                                           input logic [CNT_W-1:0]  lane);
      return word[{lane, 3'b000} +: 8];
   endfunction

   // Replace byte lane 'lane' of a word with 'data'
   function automatic logic [DATA_W-1:0] put_lane(input logic [DATA_W-1:0] word,
                                                  input logic [CNT_W-1:0]  lane,
                                                  input logic [7:0]        data);
      logic [DATA_W-1:0] w;
      w = word;
      w[{lane, 3'b000} +: 8] = data;
      return w;
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   state_e            state_q,    state_d;
   logic [ADDR_W:0]   word_ptr_q, word_ptr_d;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [DATA_W-1:0] asm_q,      asm_d;
   logic              hold_q,     hold_d;
   logic              ld_ready_q, ld_ready_d;
   logic              done_q,     done_d;
   logic              dvalid_q,   dvalid_d;
   logic [7:0]        dbyte_q,    dbyte_d;

   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_waddr_s;
   logic [DATA_W-1:0] mem_wdata_s;
   logic [DATA_W-1:0] new_word_s;
   logic [ADDR_W:0]   nxt_ptr_s;
   logic [CNT_W-1:0]  nxt_cnt_s;
   logic              dump_trig_s;

`ifdef BABY_STOP_DUMP_EN
   // stop_low_q = lamp was seen low after reset, so a level held high
   // through reset cannot look like a rising edge
   logic stop_low_q;

   // Stop-lamp edge detector state
   always_ff @(posedge fpgaGlobalClock or negedge reset_i) begin
      if (!reset_i) begin
         stop_low_q <= 1'b0;
      end else begin
         stop_low_q <= ~stop_lamp_i;
      end
   end

   assign dump_trig_s = dump_start_i | (stop_lamp_i & stop_low_q);
`else
   logic unused_stop_lamp_s;
   assign unused_stop_lamp_s = stop_lamp_i;
   assign dump_trig_s        = dump_start_i;
`endif

   // Byte/word position following the current one (shared by load and dump)
   always_comb begin
      nxt_ptr_s = word_ptr_q;
      nxt_cnt_s = byte_cnt_q + CNT_W'(1);
      if (byte_cnt_q == LAST_BYTE) begin
         nxt_ptr_s = word_ptr_q + (ADDR_W + 1)'(1);
         nxt_cnt_s = {CNT_W{1'b0}};
      end else begin
         nxt_ptr_s = word_ptr_q;
      end
   end

   // Next-state, store-port and output logic
   always_comb begin
      state_d     = state_q;
      word_ptr_d  = word_ptr_q;
      byte_cnt_d  = byte_cnt_q;
      asm_d       = asm_q;
      hold_d      = hold_q;
      ld_ready_d  = ld_ready_q;
      done_d      = 1'b0;
      dvalid_d    = dvalid_q;
      dbyte_d     = dbyte_q;
      mem_we_s    = 1'b0;
      mem_waddr_s = cpu_addr_i;
      mem_wdata_s = cpu_data_i;
      cpu_data_o  = {DATA_W{1'b0}};
      new_word_s  = put_lane(asm_q, byte_cnt_q, ld_byte_i);

      case (state_q)
         ST_IDLE: begin
            cpu_data_o = mem_q[cpu_addr_i];
            mem_we_s   = cpu_rw_en_i;
            if (ld_start_i) begin
               state_d    = ST_LOAD;
               word_ptr_d = {(ADDR_W + 1){1'b0}};
               byte_cnt_d = {CNT_W{1'b0}};
               asm_d      = {DATA_W{1'b0}};
               hold_d     = 1'b1;
               ld_ready_d = 1'b1;
            end else if (dump_trig_s) begin
               state_d    = ST_DUMP;
               word_ptr_d = {(ADDR_W + 1){1'b0}};
               byte_cnt_d = {CNT_W{1'b0}};
               hold_d     = 1'b1;
               dvalid_d   = 1'b0;
            end else begin
               hold_d     = 1'b0;
            end
         end

         ST_LOAD: begin
            if (ld_start_i) begin
               // restart: drop the partial word, keep words already written
               word_ptr_d = {(ADDR_W + 1){1'b0}};
               byte_cnt_d = {CNT_W{1'b0}};
               asm_d      = {DATA_W{1'b0}};
            end else if (ld_valid_i && ld_ready_q) begin
               asm_d      = new_word_s;
               byte_cnt_d = nxt_cnt_s;
               word_ptr_d = nxt_ptr_s;
               if (byte_cnt_q == LAST_BYTE) begin
                  mem_we_s    = 1'b1;
                  mem_waddr_s = word_ptr_q[ADDR_W-1:0];
                  mem_wdata_s = new_word_s;
                  if (word_ptr_q == LAST_WORD) begin
                     state_d    = ST_IDLE;
                     done_d     = 1'b1;
                     hold_d     = 1'b0;
                     ld_ready_d = 1'b0;
                  end else begin
                     done_d     = 1'b0;
                  end
               end else begin
                  mem_we_s = 1'b0;
               end
            end else begin
               asm_d = asm_q;
            end
         end

         ST_DUMP: begin
            if (!dvalid_q) begin
               // first byte is presented one cycle after entry
               dvalid_d = 1'b1;
               dbyte_d  = get_lane(mem_q[word_ptr_q[ADDR_W-1:0]], byte_cnt_q);
            end else if (dump_ready_i) begin
               if ((word_ptr_q == LAST_WORD) && (byte_cnt_q == LAST_BYTE)) begin
                  state_d  = ST_IDLE;
                  dvalid_d = 1'b0;
                  hold_d   = 1'b0;
               end else begin
                  word_ptr_d = nxt_ptr_s;
                  byte_cnt_d = nxt_cnt_s;
                  dbyte_d    = get_lane(mem_q[nxt_ptr_s[ADDR_W-1:0]], nxt_cnt_s);
               end
            end else begin
               dbyte_d = dbyte_q;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            hold_d     = 1'b0;
            ld_ready_d = 1'b0;
            dvalid_d   = 1'b0;
         end
      endcase
   end

   // Control and output registers
   always_ff @(posedge fpgaGlobalClock or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= ST_IDLE;
         word_ptr_q <= {(ADDR_W + 1){1'b0}};
         byte_cnt_q <= {CNT_W{1'b0}};
         asm_q      <= {DATA_W{1'b0}};
         hold_q     <= 1'b0;
         ld_ready_q <= 1'b0;
         done_q     <= 1'b0;
         dvalid_q   <= 1'b0;
         dbyte_q    <= 8'h00;
      end else begin
         state_q    <= state_d;
         word_ptr_q <= word_ptr_d;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         hold_q     <= hold_d;
         ld_ready_q <= ld_ready_d;
         done_q     <= done_d;
         dvalid_q   <= dvalid_d;
         dbyte_q    <= dbyte_d;
      end
   end

   // Store array; contents deliberately survive reset
   always_ff @(posedge fpgaGlobalClock) begin
      if (mem_we_s) begin
         mem_q[mem_waddr_s] <= mem_wdata_s;
      end
   end

   assign cpu_hold_o   = hold_q;
   assign ld_ready_o   = ld_ready_q;
   assign load_done_o  = done_q;
   assign dump_valid_o = dvalid_q;
   assign dump_byte_o  = dbyte_q;

endmodule

// File: tb/tb_baby_store_loader.sv
// -----------------------------------------------------------------------------
// tb_baby_store_loader
//
// Self-checking bench for baby_store_loader. A word-array model of the store
// is filled from the byte streams the bench sends; dumps are compared byte by
// byte against that model. Inputs are driven and outputs sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_baby_store_loader;

   logic        clk = 1'b0;
   logic        reset_i = 1'b0;
   logic [4:0]  cpu_addr_i = 5'd0;
   logic [31:0] cpu_data_i = 32'd0;
   logic        cpu_rw_en_i = 1'b0;
   logic [31:0] cpu_data_o;
   logic        stop_lamp_i = 1'b0;
   logic        cpu_hold_o;
   logic        ld_start_i = 1'b0;
   logic        ld_valid_i = 1'b0;
   logic [7:0]  ld_byte_i = 8'd0;
   logic        ld_ready_o;
   logic        load_done_o;
   logic        dump_start_i = 1'b0;
   logic        dump_valid_o;
   logic [7:0]  dump_byte_o;
   logic        dump_ready_i = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  stream    [0:255];
   logic [31:0] model_mem [0:31];

   always #5 clk = ~clk;

   baby_store_loader dut (
      .fpgaGlobalClock (clk),
      .reset_i         (reset_i),
      .cpu_addr_i      (cpu_addr_i),
      .cpu_data_i      (cpu_data_i),
      .cpu_rw_en_i     (cpu_rw_en_i),
      .cpu_data_o      (cpu_data_o),
      .stop_lamp_i     (stop_lamp_i),
      .cpu_hold_o      (cpu_hold_o),
      .ld_start_i      (ld_start_i),
      .ld_valid_i      (ld_valid_i),
      .ld_byte_i       (ld_byte_i),
      .ld_ready_o      (ld_ready_o),
      .load_done_o     (load_done_o),
      .dump_start_i    (dump_start_i),
      .dump_valid_o    (dump_valid_o),
      .dump_byte_o     (dump_byte_o),
      .dump_ready_i    (dump_ready_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [7:0] exp_byte(input int k);
      logic [31:0] w;
      w = model_mem[k / 4];
      return w[(k % 4) * 8 +: 8];
   endfunction

   // Compare every store word, read through the core port, with the model
   task automatic check_store(input string tag);
      for (int a = 0; a < 32; a++) begin
         cpu_addr_i = 5'(a);
         #1;
         check($sformatf("%s_w%0d", tag, a), cpu_data_o, model_mem[a]);
      end
   endtask

   task automatic fill_random_stream();
      for (int i = 0; i < 256; i++) stream[i] = 8'($urandom);
   endtask

   // Load session from stream[]; restart_after >= 0 pulses ld_start after that
   // many accepted bytes; max_bytes < 128 stops feeding early (no done expected)
   task automatic do_load(input int restart_after, input bit toggle,
                          input bit both_start, input int max_bytes);
      int idx, acc, cyc, dones, base_eff, nwords;
      bit restarted, hold_bad, dv_bad, cpu_bad;
      idx = 0; acc = 0; cyc = 0; dones = 0; base_eff = 0;
      restarted = (restart_after < 0);
      hold_bad = 1'b0; dv_bad = 1'b0; cpu_bad = 1'b0;
      ld_start_i = 1'b1; dump_start_i = both_start;
      tick();
      ld_start_i = 1'b0; dump_start_i = 1'b0;
      while (dones == 0 && cyc < 1000 && !(max_bytes < 128 && acc >= max_bytes)) begin
         if (!cpu_hold_o)          hold_bad = 1'b1;
         if (dump_valid_o)         dv_bad   = 1'b1;
         if (cpu_data_o != 32'd0)  cpu_bad  = 1'b1;
         if (!restarted && acc == restart_after) begin
            ld_start_i = 1'b1; ld_valid_i = 1'b0;
            restarted = 1'b1; base_eff = idx; acc = 0;
         end else begin
            ld_valid_i = toggle ? cyc[0] : 1'b1;
            ld_byte_i  = stream[idx[7:0]];
            if (ld_valid_i && ld_ready_o) begin
               idx++; acc++;
            end
         end
         cpu_rw_en_i = 1'b1; cpu_addr_i = 5'd31; cpu_data_i = $urandom;
         tick();
         ld_start_i = 1'b0; ld_valid_i = 1'b0; cpu_rw_en_i = 1'b0;
         cyc++;
         if (load_done_o) dones++;
      end
      if (max_bytes >= 128) begin
         check("load_done_seen",  32'(dones), 32'd1);
         check("load_byte_count", 32'(acc), 32'd128);
         check("load_ready_drop", 32'(ld_ready_o), 32'd0);
         check("load_hold_drop",  32'(cpu_hold_o), 32'd0);
         tick();
         check("load_done_one_cycle", 32'(load_done_o), 32'd0);
      end
      check("load_hold_high",   32'(hold_bad), 32'd0);
      check("load_no_dump",     32'(dv_bad), 32'd0);
      check("load_cpu_data_0",  32'(cpu_bad), 32'd0);
      nwords = (max_bytes >= 128) ? 32 : acc / 4;
      for (int w = 0; w < nwords; w++) begin
         int b;
         b = base_eff + 4 * w;
         model_mem[w] = {stream[b + 3], stream[b + 2], stream[b + 1], stream[b]};
      end
   endtask

   // Dump session with random sink back-pressure; stall_at >= 0 forces three
   // stalled cycles on that byte index
   task automatic do_dump(input bit via_lamp, input int stall_at);
      int k, cyc, stalls;
      bit cpu_bad;
      if (via_lamp) stop_lamp_i = 1'b1;
      else          dump_start_i = 1'b1;
      tick();
      dump_start_i = 1'b0;
      check("dump_entry_valid_low", 32'(dump_valid_o), 32'd0);
      check("dump_entry_hold",      32'(cpu_hold_o), 32'd1);
      k = 0; cyc = 0; stalls = 0; cpu_bad = 1'b0;
      while (k < 128 && cyc < 2000) begin
         if (cpu_data_o != 32'd0) cpu_bad = 1'b1;
         dump_ready_i = ($urandom_range(0, 3) != 0);
         if (dump_valid_o) begin
            if (k == stall_at && stalls < 3) begin
               dump_ready_i = 1'b0;
               stalls++;
               check($sformatf("dump_stall_hold%0d", stalls), 32'(dump_byte_o), 32'(exp_byte(k)));
            end
            if (dump_ready_i) begin
               check($sformatf("dump_byte%0d", k), 32'(dump_byte_o), 32'(exp_byte(k)));
               k++;
            end
         end
         cpu_rw_en_i = 1'b1; cpu_addr_i = 5'($urandom_range(0, 31)); cpu_data_i = $urandom;
         tick();
         dump_ready_i = 1'b0; cpu_rw_en_i = 1'b0;
         cyc++;
      end
      check("dump_count",       32'(k), 32'd128);
      check("dump_valid_drop",  32'(dump_valid_o), 32'd0);
      check("dump_hold_drop",   32'(cpu_hold_o), 32'd0);
      check("dump_cpu_data_0",  32'(cpu_bad), 32'd0);
      if (stall_at >= 0) check("dump_stall_cycles", 32'(stalls), 32'd3);
   endtask

   initial begin
      bit bad;
      // ---------------- reset ----------------
      tick(); tick();
      check("rst_hold",       32'(cpu_hold_o), 32'd0);
      check("rst_ld_ready",   32'(ld_ready_o), 32'd0);
      check("rst_load_done",  32'(load_done_o), 32'd0);
      check("rst_dump_valid", 32'(dump_valid_o), 32'd0);
      check("rst_dump_byte",  32'(dump_byte_o), 32'd0);
      reset_i = 1'b1;
      tick();

      // ---------------- core writes / async read ----------------
      for (int a = 0; a < 32; a++) begin
         cpu_addr_i = 5'(a);
         cpu_data_i = (a == 3) ? 32'hDEADBEEF : $urandom;
         model_mem[a] = cpu_data_i;
         cpu_rw_en_i = 1'b1;
         tick();
      end
      cpu_rw_en_i = 1'b0;
      cpu_addr_i = 5'd3;
      #1;
      check("cpu_read_addr3", cpu_data_o, 32'hDEADBEEF);
      check("cpu_idle_hold",  32'(cpu_hold_o), 32'd0);
      check_store("cpu_store");

      // ---------------- sequential load 0x00..0x7F ----------------
      for (int i = 0; i < 256; i++) stream[i] = 8'(i);
      do_load(-1, 1'b0, 1'b0, 128);
      cpu_addr_i = 5'd0;  #1; check("load_mem0",  cpu_data_o, 32'h03020100);
      cpu_addr_i = 5'd31; #1; check("load_mem31", cpu_data_o, 32'h7F7E7D7C);
      check_store("load_seq");

      // ---------------- dump with stall on byte 5 ----------------
      do_dump(1'b0, 5);
      check_store("after_dump");

      // ---------------- toggled-valid load with restart after 6 bytes -------
      fill_random_stream();
      do_load(6, 1'b1, 1'b0, 128);
      cpu_addr_i = 5'd0; #1;
      check("restart_word0", cpu_data_o, {stream[9], stream[8], stream[7], stream[6]});
      check_store("load_restart");
      do_dump(1'b0, int'($urandom_range(0, 127)));

      // ---------------- simultaneous starts, reset mid-load ----------------
      fill_random_stream();
      do_load(-1, 1'b0, 1'b1, 40);
      reset_i = 1'b0;
      #1;
      check("midrst_hold",       32'(cpu_hold_o), 32'd0);
      check("midrst_ld_ready",   32'(ld_ready_o), 32'd0);
      check("midrst_load_done",  32'(load_done_o), 32'd0);
      check("midrst_dump_valid", 32'(dump_valid_o), 32'd0);
      check("midrst_dump_byte",  32'(dump_byte_o), 32'd0);
      tick();
      reset_i = 1'b1;
      tick();
      check_store("midrst_store");

      // ---------------- stop lamp ----------------
      stop_lamp_i = 1'b1;
      reset_i = 1'b0;
      tick();
      reset_i = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (dump_valid_o || cpu_hold_o) bad = 1'b1;
      end
      check("lamp_level_thru_reset", 32'(bad), 32'd0);
      stop_lamp_i = 1'b0;
      tick(); tick();
`ifdef BABY_STOP_DUMP_EN
      do_dump(1'b1, 9);
`else
      stop_lamp_i = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (dump_valid_o || cpu_hold_o) bad = 1'b1;
      end
      check("lamp_no_dump", 32'(bad), 32'd0);
`endif
      stop_lamp_i = 1'b0;
      tick();
      check_store("final_store");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/baby_store_loader.md
Name: baby_store_loader

Overview:
- 32-word x 32-bit main store for the Manchester Baby core. Sits directly downstream of the core's RAM interface: consumes its address, write-data and read/write-enable outputs, and drives its read-data input.
- Adds a byte-wide host load port that fills the store, plus a byte-wide dump port that streams it back out.
- Holds the core in reset while either transfer is in progress.

Parameters:
- ADDR_W, 5: store address width; depth is 2^ADDR_W words.
- DATA_W, 32: word width. Must be a multiple of 8.
- BPW, DATA_W/8: bytes per word. Derived; do not override.

Ports:
- fpgaGlobalClock  in  1  single system clock; rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- cpu_addr_i  in  ADDR_W  core store address.
- cpu_data_i  in  DATA_W  core write data.
- cpu_rw_en_i  in  1  1 = core write this cycle.
- cpu_data_o  out  DATA_W  read data to core.
- stop_lamp_i  in  1  core halted indicator.
- cpu_hold_o  out  1  1 = hold core in reset.
- ld_start_i  in  1  pulse: begin a load session.
- ld_valid_i  in  1  load byte valid.
- ld_byte_i  in  8  load byte.
- ld_ready_o  out  1  load byte accepted when valid and ready.
- load_done_o  out  1  1-cycle pulse when the last word is written.
- dump_start_i  in  1  pulse: begin a dump session.
- dump_valid_o  out  1  dump byte valid.
- dump_byte_o  out  8  dump byte.
- dump_ready_i  in  1  sink accepts the byte.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - FSM goes to IDLE; word_ptr, byte_cnt and the assembly register clear to 0.
  - All outputs reset to 0: cpu_hold_o, ld_ready_o, load_done_o, dump_valid_o, dump_byte_o.
  - Store contents are not cleared.
- FSM states: IDLE, LOAD, DUMP.
- IDLE:
  - cpu_data_o = mem[cpu_addr_i], combinational (asynchronous read).
  - Write mem[cpu_addr_i] <= cpu_data_i on the clock edge when cpu_rw_en_i=1.
  - cpu_hold_o=0.
  - ld_start_i -> LOAD. dump_start_i -> DUMP. If both are asserted, LOAD wins.
- LOAD:
  - Entry sets word_ptr=0, byte_cnt=0, cpu_hold_o=1, ld_ready_o=1.
  - Each accepted byte goes into assembly lane byte_cnt (little-endian: first byte is bits 7:0); byte_cnt increments.
  - On the BPW-th accepted byte, write the full word (the new byte included) to mem[word_ptr] on that same edge; byte_cnt returns to 0 and word_ptr increments.
  - After the write to word 2^ADDR_W-1: go to IDLE next cycle; load_done_o=1 for that one cycle; cpu_hold_o and ld_ready_o drop the same cycle.
  - ld_start_i during LOAD restarts at word 0, byte 0. The partial word is discarded; words already written are kept.
  - dump_start_i is ignored during LOAD.
- DUMP:
  - Entry sets word_ptr=0, byte_cnt=0, cpu_hold_o=1.
  - dump_valid_o rises one cycle after entry. dump_byte_o = byte byte_cnt of mem[word_ptr], little-endian.
  - dump_byte_o is stable while dump_valid_o=1 and dump_ready_i=0.
  - Each handshake advances byte_cnt/word_ptr; a total of 2^ADDR_W*BPW bytes (128 at defaults).
  - After the last handshake: dump_valid_o=0 and IDLE next cycle.
  - ld_start_i and dump_start_i are ignored during DUMP.
- During LOAD and DUMP: cpu_data_o=0 and cpu_rw_en_i is ignored.
- word_ptr is ADDR_W+1 bits internally so the terminal word is detected without wrap aliasing.
- Reset asserted mid-session aborts it immediately. The store keeps whatever was written before the reset.

Optional Feature:
- Macro: BABY_STOP_DUMP_EN.
- Defined: a 0->1 edge on stop_lamp_i while in IDLE starts a DUMP exactly as dump_start_i would. The edge detector is a register reset to 0. A level held through reset does not trigger a dump.
- Not defined: stop_lamp_i is unused, and the port remains for interface stability.

Test Plan:
- Reset, then CPU write 0xDEADBEEF to address 3 -> cpu_data_o=0xDEADBEEF when cpu_addr_i=3; cpu_hold_o=0.
- ld_start_i, then 128 bytes 0x00..0x7F with ld_valid_i always high -> mem[0]=0x03020100, mem[31]=0x7F7E7D7C; load_done_o pulses once; cpu_hold_o high from the cycle after start until the done cycle.
- Load with ld_valid_i toggled every other cycle, then a restart via ld_start_i after 6 bytes -> word 0 = bytes 6..9 of the original stream, with no residue from the partial word.
- Dump after load with dump_ready_i low for 3 cycles on byte 5 -> dump_byte_o held at 0x05 for those cycles; stream 0x00..0x7F complete; IDLE after byte 128.
- ld_start_i and dump_start_i in the same cycle -> LOAD entered and dump_valid_o stays 0. reset_i low mid-load after 10 words -> all outputs 0; words 0..9 preserved.
- With BABY_STOP_DUMP_EN: stop_lamp_i rises in IDLE -> dump begins. Without the macro -> no dump_valid_o activity.
